imem_loader: RTL and testbench

Program loader that fills the instruction memory of the 3-stage pipelined core before it runs. It accepts 16-bit instruction words over a valid/ready stream and writes them through the instruction memory's write port (wen/addr/data_in) at consecutive addresses from 0. It holds the core in reset until the last word is committed. It sits beside the instruction memory: it drives the write side, and the core's PC/fetch path reads the same memory.

---
 rtl/imem_loader.sv | 188 ++++++++++++++++++
 tb/tb_imem_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
// Fills the instruction memory of the pipelined core before it runs. Words
// arrive on a valid/ready stream and are written through the memory write
// port at consecutive addresses starting from 0. The core is held in reset
// until the final write has left the port.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined     -> checksum is the DSIZE-bit wrap-around sum of accepted words
//   not defined -> checksum is tied to 0 and no accumulator is built
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   load_start        one-cycle load request (honoured in IDLE/DONE/ERR)
//   load_len          number of words to load, sampled with load_start
//   in_valid, in_data input word stream
//   in_ready          loader accepts a word this cycle (LOAD only)
//   mem_wen/addr/wdata registered instruction memory write port
//   core_rst          core reset, low only in DONE
//   done, err         load finished / last request was too long
//   words_loaded      words accepted in the current or last load
//   checksum          sum of accepted words (see macro above)
module imem_loader #(
  parameter int ISIZE = 16,
  parameter int DSIZE = 16,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic [ISIZE-1:0] load_len,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic             in_ready,
  output logic             mem_wen,
  output logic [ISIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  output logic             core_rst,
  output logic             done,
  output logic             err,
  output logic [ISIZE-1:0] words_loaded,
  output logic [DSIZE-1:0] checksum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  // One extra bit so DEPTH itself is representable even if DEPTH == 2**ISIZE.
  localparam logic [ISIZE:0] DEPTH_L = (ISIZE+1)'(DEPTH);

  state_t           state_r;
  logic             in_ready_r;
  logic             mem_wen_r;
  logic [ISIZE-1:0] mem_addr_r;
  logic [DSIZE-1:0] mem_wdata_r;
  logic             core_rst_r;
  logic             done_r;
  logic             err_r;
  logic [ISIZE-1:0] words_loaded_r;
  logic [ISIZE-1:0] len_r;

  logic             start_ok_s;
  logic             len_big_s;
  logic             len_zero_s;
  logic             hs_s;
  logic [ISIZE-1:0] next_count_s;

  assign start_ok_s   = load_start &&
                        ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
  assign len_big_s    = ({1'b0, load_len} > DEPTH_L);
  assign len_zero_s   = (load_len == '0);
  // in_ready_r is only ever set while in LOAD, so this is the stream handshake.
  assign hs_s         = in_valid && in_ready_r;
  assign next_count_s = words_loaded_r + ISIZE'(1);

  // Loader FSM with all control and write-port outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      in_ready_r     <= 1'b0;
      mem_wen_r      <= 1'b0;
      mem_addr_r     <= '0;
      mem_wdata_r    <= '0;
      core_rst_r     <= 1'b1;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
      words_loaded_r <= '0;
      len_r          <= '0;
    end else begin
      mem_wen_r <= 1'b0;
      case (state_r)
        IDLE, DONE, ERR: begin
          if (load_start) begin
            if (len_big_s) begin
              state_r    <= ERR;
              in_ready_r <= 1'b0;
              core_rst_r <= 1'b1;
              done_r     <= 1'b0;
              err_r      <= 1'b1;
            end else if (len_zero_s) begin
              state_r        <= DONE;
              in_ready_r     <= 1'b0;
              core_rst_r     <= 1'b0;
              done_r         <= 1'b1;
              err_r          <= 1'b0;
              words_loaded_r <= '0;
            end else begin
              state_r        <= LOAD;
              in_ready_r     <= 1'b1;
              core_rst_r     <= 1'b1;
              done_r         <= 1'b0;
              err_r          <= 1'b0;
              words_loaded_r <= '0;
              len_r          <= load_len;
            end
          end else begin
            state_r <= state_r;
          end
        end
        LOAD: begin
          if (hs_s) begin
            mem_wen_r      <= 1'b1;
            mem_addr_r     <= words_loaded_r;
            mem_wdata_r    <= in_data;
            words_loaded_r <= next_count_s;
            // Stop accepting once the final word is taken; its write is
            // still on the port during FLUSH.
            if (next_count_s == len_r) begin
              state_r    <= FLUSH;
              in_ready_r <= 1'b0;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        FLUSH: begin
          state_r    <= DONE;
          core_rst_r <= 1'b0;
          done_r     <= 1'b1;
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          core_rst_r <= 1'b1;
          done_r     <= 1'b0;
          err_r      <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DSIZE-1:0] checksum_r;

  // Wrap-around sum of accepted words, restarted by any legal load request.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_r <= '0;
    end else if (start_ok_s && !len_big_s) begin
      checksum_r <= '0;
    end else if (hs_s) begin
      checksum_r <= checksum_r + in_data;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = '0;
`endif

  assign in_ready     = in_ready_r;
  assign mem_wen      = mem_wen_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign core_rst     = core_rst_r;
  assign done         = done_r;
  assign err          = err_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CK_ON = 1'b1;
`else
  localparam bit CK_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        load_start;
  logic [15:0] load_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        mem_wen;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;
  logic [15:0] checksum;

  int n_checks = 0;
  int n_pass   = 0;

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .load_len     (load_len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_rst     (core_rst),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .checksum     (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ls;
    logic [15:0] len;
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        wen;
    logic [15:0] addr;
    logic [15:0] wd;
    logic        crst;
    logic        dn;
    logic        er;
    logic [15:0] wl;
    logic [15:0] ck;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic ls, input logic [15:0] len,
                     input logic v, input logic [15:0] d,
                     input logic rdy, input logic wen, input logic [15:0] addr,
                     input logic [15:0] wd, input logic crst, input logic dn,
                     input logic er, input logic [15:0] wl, input logic [15:0] ck);
    vec_t t;
    t.rst = r;  t.ls = ls;  t.len = len;  t.v = v;  t.d = d;
    t.rdy = rdy; t.wen = wen; t.addr = addr; t.wd = wd;
    t.crst = crst; t.dn = dn; t.er = er; t.wl = wl; t.ck = ck;
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ls, input logic [15:0] len,
                       input logic v, input logic [15:0] d);
    @(negedge clk);
    rst = r; load_start = ls; load_len = len; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t t;
    logic [15:0] exp_ck;
    logic [15:0] sum;
    string nm;

    rst = 1'b1; load_start = 1'b0; load_len = 16'd0; in_valid = 1'b0; in_data = 16'd0;

    //   rst   ls    len      v     d          rdy   wen   addr    wd         crst  dn    er    wl      ck
    // reset with in_valid held high
    add(1'b1, 1'b0, 16'd0,   1'b1, 16'hFFFF, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);
    add(1'b1, 1'b0, 16'd0,   1'b1, 16'hFFFF, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);
    // 4-word back-to-back load
    add(1'b0, 1'b1, 16'd4,   1'b1, 16'hFFFF, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h1123, 1'b1, 1'b1, 16'd0, 16'h1123, 1'b1, 1'b0, 1'b0, 16'd1, 16'h1123);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h2234, 1'b1, 1'b1, 16'd1, 16'h2234, 1'b1, 1'b0, 1'b0, 16'd2, 16'h3357);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h3345, 1'b1, 1'b1, 16'd2, 16'h3345, 1'b1, 1'b0, 1'b0, 16'd3, 16'h669C);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h4456, 1'b0, 1'b1, 16'd3, 16'h4456, 1'b1, 1'b0, 1'b0, 16'd4, 16'hAAF2);
    add(1'b0, 1'b0, 16'd0,   1'b0, 16'h0000, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd4, 16'hAAF2);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h5555, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd4, 16'hAAF2);
    // reload from DONE, 3 words with valid on alternate cycles
    add(1'b0, 1'b1, 16'd3,   1'b0, 16'h0000, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);
    add(1'b0, 1'b0, 16'd0,   1'b0, 16'h0000, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h0A0A, 1'b1, 1'b1, 16'd0, 16'h0A0A, 1'b1, 1'b0, 1'b0, 16'd1, 16'h0A0A);
    add(1'b0, 1'b0, 16'd0,   1'b0, 16'h0000, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd1, 16'h0A0A);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h0B0B, 1'b1, 1'b1, 16'd1, 16'h0B0B, 1'b1, 1'b0, 1'b0, 16'd2, 16'h1515);
    add(1'b0, 1'b0, 16'd0,   1'b0, 16'h0000, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd2, 16'h1515);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h0C0C, 1'b0, 1'b1, 16'd2, 16'h0C0C, 1'b1, 1'b0, 1'b0, 16'd3, 16'h2121);
    add(1'b0, 1'b0, 16'd0,   1'b0, 16'h0000, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd3, 16'h2121);
    // zero-length load goes straight to DONE
    add(1'b0, 1'b1, 16'd0,   1'b0, 16'h0000, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd0, 16'h0000);
    // too long -> ERR, stream ignored
    add(1'b0, 1'b1, 16'd257, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'd0, 16'h0000);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h1234, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'd0, 16'h0000);
    // legal start from ERR, reset after 2 of 5 words
    add(1'b0, 1'b1, 16'd5,   1'b0, 16'h0000, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h0001, 1'b1, 1'b1, 16'd0, 16'h0001, 1'b1, 1'b0, 1'b0, 16'd1, 16'h0001);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h0002, 1'b1, 1'b1, 16'd1, 16'h0002, 1'b1, 1'b0, 1'b0, 16'd2, 16'h0003);
    add(1'b1, 1'b0, 16'd0,   1'b1, 16'h0003, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);
    // restart 5 words from address 0; load_start mid-load is ignored
    add(1'b0, 1'b1, 16'd5,   1'b0, 16'h0000, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h0010, 1'b1, 1'b1, 16'd0, 16'h0010, 1'b1, 1'b0, 1'b0, 16'd1, 16'h0010);
    add(1'b0, 1'b1, 16'd2,   1'b1, 16'h0020, 1'b1, 1'b1, 16'd1, 16'h0020, 1'b1, 1'b0, 1'b0, 16'd2, 16'h0030);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h0030, 1'b1, 1'b1, 16'd2, 16'h0030, 1'b1, 1'b0, 1'b0, 16'd3, 16'h0060);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h0040, 1'b1, 1'b1, 16'd3, 16'h0040, 1'b1, 1'b0, 1'b0, 16'd4, 16'h00A0);
    add(1'b0, 1'b0, 16'd0,   1'b1, 16'h0050, 1'b0, 1'b1, 16'd4, 16'h0050, 1'b1, 1'b0, 1'b0, 16'd5, 16'h00F0);
    add(1'b0, 1'b0, 16'd0,   1'b0, 16'h0000, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd5, 16'h00F0);

    for (int i = 0; i < vq.size(); i++) begin
      t = vq[i];
      drive(t.rst, t.ls, t.len, t.v, t.d);
      exp_ck = CK_ON ? t.ck : 16'h0000;
      nm = $sformatf("vec%0d ctl{rdy,wen,crst,done,err,wl,ck}", i);
      check(nm, {in_ready, mem_wen, core_rst, done, err, words_loaded, checksum},
                {t.rdy, t.wen, t.crst, t.dn, t.er, t.wl, exp_ck});
      if (t.wen) begin
        nm = $sformatf("vec%0d wr{addr,data}", i);
        check(nm, {mem_addr, mem_wdata}, {t.addr, t.wd});
      end
    end

    // Full-depth load: every legal address written, then release.
    drive(1'b0, 1'b1, 16'd256, 1'b0, 16'h0000);
    check("depth_start rdy", {in_ready, core_rst, done, err}, {1'b1, 1'b1, 1'b0, 1'b0});
    sum = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b0, 16'd0, 1'b1, 16'(i * 3 + 7));
      sum = sum + 16'(i * 3 + 7);
      nm = $sformatf("depth_wr%0d {wen,addr,data,rdy}", i);
      check(nm, {mem_wen, mem_addr, mem_wdata, in_ready},
                {1'b1, 16'(i), 16'(i * 3 + 7), (i != 255)});
    end
    drive(1'b0, 1'b0, 16'd0, 1'b1, 16'hDEAD);
    exp_ck = CK_ON ? sum : 16'h0000;
    check("depth_done {wen,crst,done,wl,ck}",
          {mem_wen, core_rst, done, words_loaded, checksum},
          {1'b0, 1'b0, 1'b1, 16'd256, exp_ck});

    // Reload from DONE: core reset reasserted the very next cycle.
    drive(1'b0, 1'b1, 16'd1, 1'b0, 16'h0000);
    check("reload {rdy,crst,done,wl}", {in_ready, core_rst, done, words_loaded},
          {1'b1, 1'b1, 1'b0, 16'd0});
    drive(1'b0, 1'b0, 16'd0, 1'b1, 16'h7777);
    check("reload_wr {wen,addr,data}", {mem_wen, mem_addr, mem_wdata},
          {1'b1, 16'd0, 16'h7777});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
